ethernet_config_regs: RTL and testbench
=======================================

# ethernet_config_regs

Management-side producer of the Ethernet configuration bus that the per-domain register CDC consumes. Accepts 16-bit microcontroller register writes and reads in the clk_250mhz domain, stages the multi-word MAC and IPv4 fields, and atomically publishes them with one-cycle `*_updated` strobes. A per-channel holdoff guarantees that the downstream synchronizers always finish one transfer before the next strobe arrives.

## Interface
- HOLDOFF, 32: minimum cycles between successive `*_updated` pulses on one channel; legal range 2..255.
- DEFAULT_MAC, 48'h02_00_00_00_00_01: MAC value after reset.
- DEFAULT_IP, 96'h0: IPv4Config value after reset, ordered {address, mask, gateway}.
- clk_250mhz  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  8  word address.
- wr_data  in  16  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  8  word address.
- rd_data  out  16  read data.
- rd_valid  out  1  read data qualifier.
- mac_address  out  48  committed MAC.
- mac_address_updated  out  1  one-cycle publish strobe.
- ip_config  out  IPv4Config (96)  committed {address, mask, gateway}.
- ip_config_updated  out  1  one-cycle publish strobe.

## Operation
- Register map, word addresses, big-endian (lower address holds the higher bits):
  - 0x00..0x02: MAC staging.
  - 0x03: MAC commit (write only; data ignored).
  - 0x04..0x05: IP address staging.
  - 0x06..0x07: mask staging.
  - 0x08..0x09: gateway staging.
  - 0x0A: IP commit (write only).
  - 0x0B: status (read only); bit0 = MAC pending, bit1 = IP pending, remaining bits 0.
- Reads of 0x00..0x09 return staging contents, not committed values. Reads of unmapped addresses and of 0x03/0x0A return 0. Writes to unmapped addresses and to 0x0B are ignored.
- Each channel (MAC, IP) is an independent commit unit with two states:
  - READY (holdoff counter = 0): a commit write copies staging to the output register, pulses `updated`, loads the counter with HOLDOFF−1, and enters HOLDOFF.
  - HOLDOFF: the counter decrements each cycle. A commit write sets `pending`; repeated commits collapse into one. When the counter reaches 0: if `pending`, perform the copy, pulse, reload, clear `pending`, and stay in HOLDOFF; otherwise go to READY.
- The deferred copy takes staging as registered at the firing cycle. A staging write in that same cycle lands after the copy and is not included.
- Boot publish: the first clock edge after rst_n deasserts behaves as a commit on both channels, so defaults reach all domains.
- The two channels never interact. Simultaneous strobes are legal.

## Timing
- Reset values:
  - mac_address = DEFAULT_MAC; ip_config = DEFAULT_IP.
  - Staging = defaults; `*_updated` = 0; `pending` = 0.
  - rd_data = 0; rd_valid = 0; counters = 0.
- Commit in READY: write at edge N produces outputs changed and `updated` high during cycle N+1. Outputs never change in any cycle without a strobe.
- Strobe spacing on one channel is at least HOLDOFF cycles. A pending commit fires exactly HOLDOFF cycles after the previous strobe.
- Read: rd_en at edge N gives rd_data / rd_valid during cycle N+1. rd_valid is high for one cycle; rd_data holds its value afterwards. Read and write in the same cycle to the same address return the old value.
- Reset asserted mid-holdoff: all state returns to reset values immediately and the boot publish repeats after release.

## Structure
- Shared package: register address constants, and status bit positions. The IPv4Config typedef already lives there and is reused.
- Sub-module config_commit_channel, parameterized by WIDTH and HOLDOFF, instantiated twice. Inputs: commit, staging; outputs: value, updated, pending.
- Top level contains address decode, staging registers and the read mux.

## Test plan
- Reset release → mac_address_updated and ip_config_updated high one cycle after release, with mac_address = 02:00:00:00:00:01.
- Write 0x0011, 0x2233, 0x4455 to 0x00..0x02, then commit 0x03 → strobe at +1 cycle, mac_address = 48'h001122334455.
- After the boot pulse, three IP commits 5, 10 and 20 cycles later (HOLDOFF = 32) → one strobe exactly 32 cycles after the boot strobe, carrying the staging value at firing; status bit1 = 1 until then.
- Staging write to 0x05 in the same cycle a pending IP commit fires → published address excludes the new word; a later commit includes it.
- Read 0x01 after the MAC writes → rd_valid at +1 with rd_data = 16'h2233; read 0x03 or 0x3F → 16'h0000.
- Assert rst_n mid-holdoff with MAC pending → outputs return to defaults, pending is cleared, and a fresh boot pulse follows release.

Source files
------------

// File: rtl/ethernet_config_regs_pkg.sv
// Shared definitions for the Ethernet configuration register block:
// payload types, register map and status bit positions.
package ethernet_config_regs_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned IP_W   = 96;
  localparam int unsigned CNT_W  = 8;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] mask;
    logic [31:0] gateway;
  } ipv4_config_t;

  localparam logic [ADDR_W-1:0] ADDR_MAC_0      = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_MAC_1      = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_MAC_2      = 8'h02;
  localparam logic [ADDR_W-1:0] ADDR_MAC_COMMIT = 8'h03;
  localparam logic [ADDR_W-1:0] ADDR_IP_ADDR_0  = 8'h04;
  localparam logic [ADDR_W-1:0] ADDR_IP_ADDR_1  = 8'h05;
  localparam logic [ADDR_W-1:0] ADDR_IP_MASK_0  = 8'h06;
  localparam logic [ADDR_W-1:0] ADDR_IP_MASK_1  = 8'h07;
  localparam logic [ADDR_W-1:0] ADDR_IP_GW_0    = 8'h08;
  localparam logic [ADDR_W-1:0] ADDR_IP_GW_1    = 8'h09;
  localparam logic [ADDR_W-1:0] ADDR_IP_COMMIT  = 8'h0A;
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 8'h0B;

  localparam int unsigned STATUS_MAC_PENDING = 0;
  localparam int unsigned STATUS_IP_PENDING  = 1;

  typedef enum logic {
    ST_READY   = 1'b0,
    ST_HOLDOFF = 1'b1
  } commit_state_e;

endpackage

// File: rtl/ethernet_config_regs_commit_channel.sv
// One atomic publish channel: copies staging to the output with an updated
// strobe, and spaces strobes at least HOLDOFF cycles apart, collapsing commits.
module config_commit_channel
  import ethernet_config_regs_pkg::*;
#(
  parameter int unsigned      WIDTH       = 48,
  parameter int unsigned      HOLDOFF     = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  input  logic [WIDTH-1:0] staging,
  output logic [WIDTH-1:0] value,
  output logic             updated,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLDOFF - 1);

  commit_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_d, updated_d;
  logic [WIDTH-1:0] value_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_READY;
      cnt_q   <= '0;
      pending <= 1'b0;
      updated <= 1'b0;
      value   <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pending <= pending_d;
      updated <= updated_d;
      value   <= value_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending;
    updated_d = 1'b0;
    value_d   = value;
    case (state_q)
      ST_READY: begin
        if (commit) begin
          value_d   = staging;
          updated_d = 1'b1;
          cnt_d     = RELOAD;
          state_d   = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (commit) pending_d = 1'b1;
        end else if (pending || commit) begin
          // Holdoff expired with a commit outstanding: fire exactly now.
          value_d   = staging;
          updated_d = 1'b1;
          cnt_d     = RELOAD;
          pending_d = 1'b0;
        end else begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

endmodule

// File: rtl/ethernet_config_regs.sv
// Management register front end: decodes 16-bit word writes into MAC/IPv4
// staging, serves reads, and publishes committed values through two channels.
module ethernet_config_regs
  import ethernet_config_regs_pkg::*;
#(
  parameter int unsigned      HOLDOFF     = 32,
  parameter logic [MAC_W-1:0] DEFAULT_MAC = 48'h02_00_00_00_00_01,
  parameter logic [IP_W-1:0]  DEFAULT_IP  = 96'h0
) (
  input  logic              clk_250mhz,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [MAC_W-1:0]  mac_address,
  output logic              mac_address_updated,
  output ipv4_config_t      ip_config,
  output logic              ip_config_updated
);

  logic [MAC_W-1:0]  mac_stg;
  ipv4_config_t      ip_stg;
  logic              boot_done;
  logic              mac_commit_c, ip_commit_c;
  logic              mac_pending, ip_pending;
  logic [DATA_W-1:0] rd_mux_c;

  // Staging registers, big-endian word order.
  always_ff @(posedge clk_250mhz or negedge rst_n) begin
    if (!rst_n) begin
      mac_stg <= DEFAULT_MAC;
      ip_stg  <= ipv4_config_t'(DEFAULT_IP);
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_MAC_0:     mac_stg[47:32]         <= wr_data;
        ADDR_MAC_1:     mac_stg[31:16]         <= wr_data;
        ADDR_MAC_2:     mac_stg[15:0]          <= wr_data;
        ADDR_IP_ADDR_0: ip_stg.address[31:16]  <= wr_data;
        ADDR_IP_ADDR_1: ip_stg.address[15:0]   <= wr_data;
        ADDR_IP_MASK_0: ip_stg.mask[31:16]     <= wr_data;
        ADDR_IP_MASK_1: ip_stg.mask[15:0]      <= wr_data;
        ADDR_IP_GW_0:   ip_stg.gateway[31:16]  <= wr_data;
        ADDR_IP_GW_1:   ip_stg.gateway[15:0]   <= wr_data;
        default: ;
      endcase
    end
  end

  // First edge out of reset acts as a commit so defaults get published.
  always_ff @(posedge clk_250mhz or negedge rst_n) begin
    if (!rst_n) boot_done <= 1'b0;
    else        boot_done <= 1'b1;
  end

  assign mac_commit_c = !boot_done || (wr_en && wr_addr == ADDR_MAC_COMMIT);
  assign ip_commit_c  = !boot_done || (wr_en && wr_addr == ADDR_IP_COMMIT);

  always_comb begin
    rd_mux_c = '0;
    case (rd_addr)
      ADDR_MAC_0:     rd_mux_c = mac_stg[47:32];
      ADDR_MAC_1:     rd_mux_c = mac_stg[31:16];
      ADDR_MAC_2:     rd_mux_c = mac_stg[15:0];
      ADDR_IP_ADDR_0: rd_mux_c = ip_stg.address[31:16];
      ADDR_IP_ADDR_1: rd_mux_c = ip_stg.address[15:0];
      ADDR_IP_MASK_0: rd_mux_c = ip_stg.mask[31:16];
      ADDR_IP_MASK_1: rd_mux_c = ip_stg.mask[15:0];
      ADDR_IP_GW_0:   rd_mux_c = ip_stg.gateway[31:16];
      ADDR_IP_GW_1:   rd_mux_c = ip_stg.gateway[15:0];
      ADDR_STATUS: begin
        rd_mux_c[STATUS_MAC_PENDING] = mac_pending;
        rd_mux_c[STATUS_IP_PENDING]  = ip_pending;
      end
      default: ;
    endcase
  end

  // rd_data holds the last read value between strobes.
  always_ff @(posedge clk_250mhz or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux_c;
    end
  end

  config_commit_channel #(
    .WIDTH       (MAC_W),
    .HOLDOFF     (HOLDOFF),
    .RESET_VALUE (DEFAULT_MAC)
  ) u_mac_channel (
    .clk     (clk_250mhz),
    .rst_n   (rst_n),
    .commit  (mac_commit_c),
    .staging (mac_stg),
    .value   (mac_address),
    .updated (mac_address_updated),
    .pending (mac_pending)
  );

  config_commit_channel #(
    .WIDTH       (IP_W),
    .HOLDOFF     (HOLDOFF),
    .RESET_VALUE (DEFAULT_IP)
  ) u_ip_channel (
    .clk     (clk_250mhz),
    .rst_n   (rst_n),
    .commit  (ip_commit_c),
    .staging (ip_stg),
    .value   (ip_config),
    .updated (ip_config_updated),
    .pending (ip_pending)
  );

endmodule

// File: tb/tb_ethernet_config_regs.sv
// Directed bench for ethernet_config_regs: boot publish, holdoff collapsing,
// same-cycle staging race, register reads and mid-holdoff reset.
module tb_ethernet_config_regs;
  import ethernet_config_regs_pkg::*;

  localparam int unsigned      HOLDOFF = 32;
  localparam logic [MAC_W-1:0] DEF_MAC = 48'h02_00_00_00_00_01;
  localparam logic [IP_W-1:0]  IP_A    = {32'hC0A8_0001, 32'hFFFF_FF00, 32'hC0A8_00FE};
  localparam logic [IP_W-1:0]  IP_B    = {32'hC0A8_0099, 32'hFFFF_FF00, 32'hC0A8_00FE};

  logic              clk_250mhz = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [MAC_W-1:0]  mac_address;
  logic              mac_address_updated;
  ipv4_config_t      ip_config;
  logic              ip_config_updated;

  int checks = 0;
  int errors = 0;

  ethernet_config_regs #(.HOLDOFF(HOLDOFF)) dut (
    .clk_250mhz          (clk_250mhz),
    .rst_n               (rst_n),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .rd_en               (rd_en),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .mac_address         (mac_address),
    .mac_address_updated (mac_address_updated),
    .ip_config           (ip_config),
    .ip_config_updated   (ip_config_updated)
  );

  always #2 clk_250mhz = ~clk_250mhz;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive one cycle of stimulus, return at next negedge.
  task automatic cyc(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                     input logic re, input logic [7:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    @(negedge clk_250mhz);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    logic              we, re;
    logic [ADDR_W-1:0] wa, ra;
    logic [DATA_W-1:0] wd;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk_250mhz);
    check("rst_mac", mac_address, DEF_MAC);
    check("rst_ip", ip_config, '0);
    check("rst_upd", {mac_address_updated, ip_config_updated}, 2'b00);
    check("rst_rd", {rd_valid, rd_data}, 17'h0);

    // Boot publish on the first edge after release.
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 16'h0, 1'b0, 8'h00);
    check("boot_upd", {mac_address_updated, ip_config_updated}, 2'b11);
    check("boot_mac", mac_address, DEF_MAC);
    check("boot_ip", ip_config, '0);

    // IP commits at +5/+10/+20 collapse into one strobe at +32; 0x05 rewritten at +32.
    for (int k = 1; k <= 66; k++) begin
      we = 1'b0; wa = '0; wd = '0; re = 1'b0; ra = '0;
      case (k)
        1:  begin we = 1'b1; wa = 8'h04; wd = 16'hC0A8; end
        2:  begin we = 1'b1; wa = 8'h05; wd = 16'h0001; end
        3:  begin we = 1'b1; wa = 8'h06; wd = 16'hFFFF; end
        4:  begin we = 1'b1; wa = 8'h07; wd = 16'hFF00; end
        5, 10, 20, 33: begin we = 1'b1; wa = 8'h0A; end
        6:  begin we = 1'b1; wa = 8'h08; wd = 16'hC0A8; end
        7:  begin we = 1'b1; wa = 8'h09; wd = 16'h00FE; end
        15, 40: begin re = 1'b1; ra = 8'h0B; end
        32: begin we = 1'b1; wa = 8'h05; wd = 16'h0099; end
        default: ;
      endcase
      cyc(we, wa, wd, re, ra);
      check("ip_upd", ip_config_updated, (k == 32 || k == 64));
      check("mac_upd_idle", mac_address_updated, 1'b0);
      if (k == 31) check("ip_hold", ip_config, '0);
      if (k == 32) check("ip_fire", ip_config, IP_A);
      if (k == 63) check("ip_hold2", ip_config, IP_A);
      if (k == 64) check("ip_fire2", ip_config, IP_B);
      if (k == 15 || k == 40) check("status_ip", {rd_valid, rd_data}, {1'b1, 16'h0002});
    end

    // MAC staging and reads.
    cyc(1'b1, 8'h00, 16'h0011, 1'b0, 8'h00);
    cyc(1'b1, 8'h01, 16'h2233, 1'b0, 8'h00);
    cyc(1'b1, 8'h02, 16'h4455, 1'b0, 8'h00);
    check("mac_unchanged", mac_address, DEF_MAC);
    cyc(1'b0, 8'h00, 16'h0, 1'b1, 8'h01);
    check("rd_01", {rd_valid, rd_data}, {1'b1, 16'h2233});
    cyc(1'b0, 8'h00, 16'h0, 1'b0, 8'h00);
    check("rd_hold", {rd_valid, rd_data}, {1'b0, 16'h2233});
    cyc(1'b0, 8'h00, 16'h0, 1'b1, 8'h03);
    check("rd_03", {rd_valid, rd_data}, {1'b1, 16'h0000});
    cyc(1'b0, 8'h00, 16'h0, 1'b1, 8'h04);
    check("rd_04", rd_data, 16'hC0A8);
    cyc(1'b0, 8'h00, 16'h0, 1'b1, 8'h3F);
    check("rd_3f", {rd_valid, rd_data}, {1'b1, 16'h0000});
    cyc(1'b1, 8'h0B, 16'hFFFF, 1'b1, 8'h0B);
    check("status_wr_ignored", rd_data, 16'h0000);
    cyc(1'b1, 8'h0A, 16'h0, 1'b1, 8'h0A);
    check("rd_0a", rd_data, 16'h0000);
    check("ip_ready_commit", ip_config_updated, 1'b0);

    // MAC commit from READY, then a second commit goes pending.
    cyc(1'b1, 8'h03, 16'hDEAD, 1'b0, 8'h00);
    check("mac_upd", mac_address_updated, 1'b1);
    check("mac_val", mac_address, 48'h0011_2233_4455);
    cyc(1'b1, 8'h00, 16'hAAAA, 1'b1, 8'h00);
    check("rd_wr_same", rd_data, 16'h0011);
    check("mac_upd_once", mac_address_updated, 1'b0);
    cyc(1'b1, 8'h03, 16'h0, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 16'h0, 1'b1, 8'h0B);
    check("status_mac", rd_data[1:0], 2'b11);

    // Reset mid-holdoff.
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_mac", mac_address, DEF_MAC);
    check("mid_rst_ip", ip_config, '0);
    check("mid_rst_rd", {rd_valid, rd_data, mac_address_updated, ip_config_updated}, 19'h0);
    @(negedge clk_250mhz);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 16'h0, 1'b1, 8'h0B);
    check("reboot_upd", {mac_address_updated, ip_config_updated}, 2'b11);
    check("reboot_mac", mac_address, DEF_MAC);
    check("reboot_status", rd_data, 16'h0000);
    cyc(1'b0, 8'h00, 16'h0, 1'b1, 8'h0B);
    check("reboot_pending", rd_data, 16'h0000);
    check("reboot_upd_off", {mac_address_updated, ip_config_updated}, 2'b00);
    repeat (40) cyc(1'b0, 8'h00, 16'h0, 1'b0, 8'h00);
    check("no_stale_fire", mac_address, DEF_MAC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
